// File: rtl/io_pkg.sv
// io_pkg: shared defaults and button FSM state type for io_input_conditioner
package io_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF = 20;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: parameterized multi-stage flip-flop synchronizer for an asynchronous bus
module sync_ff #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] chain [STAGES];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  assign q = chain[STAGES-1];
endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronize and debounce switches and interrupt button,
// latching a press into int_req until the core acknowledges it.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_raw,
  input  logic             int_ack,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             btn_level,
  output logic             int_req,
  output logic             int_overrun
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sw_n, sw_s;
  logic [CNT_W-1:0] sw_cnt, btn_cnt, btn_cnt_d;
  logic btn_s, press;
  btn_state_t state, state_d;
  // The last switch stage is kept here so sw_n (the next sw_s) can restart the count on the edge a change lands.
  sync_ff #(.W(WIDTH), .STAGES(SYNC_STAGES - 1)) u_sw_sync (
    .clk(clk), .resetn(resetn), .d(sw_raw), .q(sw_n)
  );
  sync_ff #(.W(1), .STAGES(SYNC_STAGES)) u_btn_sync (
    .clk(clk), .resetn(resetn), .d(btn_raw), .q(btn_s)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sw_s <= '0;
      sw_stable <= '0;
      sw_changed <= 1'b0;
      sw_cnt <= '0;
    end else begin
      sw_s <= sw_n;
      sw_changed <= 1'b0;
      if (sw_s == sw_stable || sw_n != sw_s) sw_cnt <= '0;
      else if (sw_cnt == LAST) begin
        sw_stable <= sw_s;
        sw_changed <= 1'b1;
        sw_cnt <= '0;
      end else sw_cnt <= sw_cnt + CNT_W'(1);
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      btn_cnt <= '0;
      int_req <= 1'b0;
      int_overrun <= 1'b0;
    end else begin
      state <= state_d;
      btn_cnt <= btn_cnt_d;
      if (press) begin
        int_req <= 1'b1;
        if (int_req && !int_ack) int_overrun <= 1'b1;
      end else if (int_ack) begin
        int_req <= 1'b0;
        int_overrun <= 1'b0;
      end
    end
  always_comb begin
    state_d = state;
    btn_cnt_d = btn_cnt;
    press = 1'b0;
    case (state)
      IDLE: if (btn_s) begin
        state_d = PRESS_WAIT;
        btn_cnt_d = '0;
      end
      PRESS_WAIT: if (!btn_s) state_d = IDLE;
        else if (btn_cnt == LAST) begin
          state_d = PRESSED;
          press = 1'b1;
        end else btn_cnt_d = btn_cnt + CNT_W'(1);
      PRESSED: if (!btn_s) begin
        state_d = RELEASE_WAIT;
        btn_cnt_d = '0;
      end
      RELEASE_WAIT: if (btn_s) state_d = PRESSED;
        else if (btn_cnt == LAST) state_d = IDLE;
        else btn_cnt_d = btn_cnt + CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end
  assign btn_level = state == PRESSED || state == RELEASE_WAIT;
endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner: table, directed and random checks against a window-based reference model
module tb_io_input_conditioner;
  localparam int W = 16;
  localparam int D = 4;
  typedef struct {
    logic [W-1:0] sw;
    int           hold;
    logic [W-1:0] exp_stable;
    int           exp_pulses;
  } vec_t;
  logic clk = 1'b0, resetn = 1'b0, btn_raw = 1'b0, int_ack = 1'b0;
  logic [W-1:0] sw_raw = '0, sw_stable;
  logic sw_changed, btn_level, int_req, int_overrun;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_stable;
  logic m_changed, m_level, m_req, m_ovr;
  logic [W-1:0] sh [D+1];
  logic bh [D+2];
  vec_t tbl [8];
  logic [W-1:0] pick [4];
  always #5 clk = ~clk;
  io_input_conditioner #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .sw_raw(sw_raw), .btn_raw(btn_raw), .int_ack(int_ack),
    .sw_stable(sw_stable), .sw_changed(sw_changed), .btn_level(btn_level),
    .int_req(int_req), .int_overrun(int_overrun)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_clear();
    m_stable = '0; m_changed = 0; m_level = 0; m_req = 0; m_ovr = 0;
    for (int i = 0; i <= D; i++) sh[i] = '0;
    for (int i = 0; i <= D + 1; i++) bh[i] = 1'b0;
  endtask
  // Switch accepts a value seen for D+1 consecutive raw samples; button toggles level after D+1 opposite btn_s samples.
  task automatic tick();
    logic acc, hit, prs;
    @(posedge clk);
    if (resetn) begin
      acc = sh[0] != m_stable;
      for (int i = 1; i <= D; i++) if (sh[i] != sh[0]) acc = 0;
      m_changed = acc;
      if (acc) m_stable = sh[0];
      hit = 1;
      for (int i = 1; i <= D + 1; i++) if (bh[i] == m_level) hit = 0;
      prs = hit && !m_level;
      if (hit) m_level = ~m_level;
      if (prs) begin
        if (m_req && !int_ack) m_ovr = 1;
        m_req = 1;
      end else if (int_ack) begin
        m_req = 0; m_ovr = 0;
      end
      for (int i = D; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = sw_raw;
      for (int i = D + 1; i > 0; i--) bh[i] = bh[i-1];
      bh[0] = btn_raw;
    end
    #1;
    chk("m_sw_stable", 32'(sw_stable), 32'(m_stable));
    chk("m_sw_changed", 32'(sw_changed), 32'(m_changed));
    chk("m_btn_level", 32'(btn_level), 32'(m_level));
    chk("m_int_req", 32'(int_req), 32'(m_req));
    chk("m_int_overrun", 32'(int_overrun), 32'(m_ovr));
  endtask
  task automatic press_btn();
    btn_raw = 1;
    repeat (7) tick();
  endtask
  task automatic release_btn();
    btn_raw = 0;
    repeat (10) tick();
  endtask
  initial begin
    int pulses;
    tbl[0] = '{16'h1234, 10, 16'h1234, 1};
    tbl[1] = '{16'h5555, 3, 16'h1234, 0};
    tbl[2] = '{16'hBEEF, 8, 16'hBEEF, 1};
    tbl[3] = '{16'h1234, 4, 16'hBEEF, 0};
    tbl[4] = '{16'h1234, 2, 16'h1234, 1};
    tbl[5] = '{16'hFFFF, 4, 16'h1234, 0};
    tbl[6] = '{16'h00FF, 6, 16'h00FF, 1};
    tbl[7] = '{16'h0000, 7, 16'h0000, 1};
    pick[0] = 16'h0000; pick[1] = 16'h0001; pick[2] = 16'h00A5; pick[3] = 16'hFFFF;
    model_clear();
    repeat (3) tick();
    chk("rst_sw_stable", 32'(sw_stable), 0);
    chk("rst_int_req", 32'(int_req), 0);
    #3 resetn = 1;
    repeat (3) tick();
    sw_raw = 16'h00A5;
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 6) pulses += int'(sw_changed);
      if (k == 5) chk("accept_early", 32'(sw_stable), 0);
      if (k == 6) begin
        chk("accept_stable", 32'(sw_stable), 32'h00A5);
        chk("accept_pulse", 32'(sw_changed), 1);
      end
      if (k == 7) chk("accept_pulse_end", 32'(sw_changed), 0);
    end
    chk("accept_no_early_pulse", 32'(pulses), 0);
    foreach (tbl[i]) begin
      sw_raw = tbl[i].sw;
      pulses = 0;
      repeat (tbl[i].hold) begin
        tick();
        pulses += int'(sw_changed);
      end
      chk($sformatf("tbl%0d_stable", i), 32'(sw_stable), 32'(tbl[i].exp_stable));
      chk($sformatf("tbl%0d_pulses", i), 32'(pulses), 32'(tbl[i].exp_pulses));
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      sw_raw = ((c / 2) % 2 == 1) ? 16'h0001 : 16'h0000;
      tick();
      pulses += int'(sw_changed);
    end
    sw_raw = 16'h0000;
    repeat (8) begin
      tick();
      pulses += int'(sw_changed);
    end
    chk("bounce_stable", 32'(sw_stable), 0);
    chk("bounce_pulses", 32'(pulses), 0);
    btn_raw = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) chk("press_level_early", 32'(btn_level), 0);
    end
    chk("press_level", 32'(btn_level), 1);
    chk("press_req", 32'(int_req), 1);
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("ack_req", 32'(int_req), 0);
    chk("ack_level_held", 32'(btn_level), 1);
    release_btn();
    chk("release_level", 32'(btn_level), 0);
    press_btn();
    chk("ovr_first_req", 32'(int_req), 1);
    chk("ovr_first_flag", 32'(int_overrun), 0);
    release_btn();
    press_btn();
    chk("ovr_second_flag", 32'(int_overrun), 1);
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("ovr_ack_req", 32'(int_req), 0);
    chk("ovr_ack_flag", 32'(int_overrun), 0);
    release_btn();
    press_btn();
    release_btn();
    btn_raw = 1;
    repeat (6) tick();
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("simul_req", 32'(int_req), 1);
    chk("simul_ovr", 32'(int_overrun), 0);
    sw_raw = 16'h0F0F;
    repeat (7) tick();
    chk("pre_rst_stable", 32'(sw_stable), 32'h0F0F);
    sw_raw = 16'hFFFF;
    repeat (3) tick();
    btn_raw = 0;
    resetn = 0;
    #1;
    chk("midrst_stable", 32'(sw_stable), 0);
    chk("midrst_changed", 32'(sw_changed), 0);
    chk("midrst_level", 32'(btn_level), 0);
    chk("midrst_req", 32'(int_req), 0);
    chk("midrst_ovr", 32'(int_overrun), 0);
    model_clear();
    repeat (2) tick();
    #3 resetn = 1;
    pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) pulses += int'(sw_changed);
    end
    chk("postrst_no_pulse", 32'(pulses), 0);
    chk("postrst_stable", 32'(sw_stable), 32'hFFFF);
    chk("postrst_pulse", 32'(sw_changed), 1);
    for (int it = 0; it < 250; it++) begin
      sw_raw = pick[$urandom_range(0, 3)];
      btn_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) begin
        int_ack = ($urandom_range(0, 5) == 0);
        tick();
      end
      int_ack = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
